uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Serializing UART transmitter for the CPU-side debug/communication path.
- Accepts one 32-bit word through a valid/ready handshake, e.g. the current PC or a memory readback.
- Sends the word on the serial line as four consecutive 8N1 frames, least significant byte first.
- It is the transmit counterpart of the word-assembling receive path in the com controller. It drives `tx` directly.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud); must be >= 2.
- BYTES_PER_WORD, 4, number of bytes sent per accepted word; the word width is 8*BYTES_PER_WORD.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- word_in  input  32  word to transmit (width 8*BYTES_PER_WORD)
- word_valid  input  1  word_in is valid
- word_ready  output  1  block can accept a word this cycle
- tx  output  1  UART serial line, idle high
- busy  output  1  a transmission is in progress
- word_done  output  1  one-cycle pulse when the last stop bit of a word finishes

Behaviour:
- Reset: on a clk edge with reset==0: tx=1, word_ready=0, busy=0, word_done=0; all counters and the shift register are cleared; state=IDLE. The next cycle after reset releases, word_ready=1.
- Reset mid-operation: the transmission is aborted with no partial completion. tx returns high at the reset edge, and no word_done pulse is produced.
- State machine:
  - IDLE: word_ready=1, busy=0, tx=1. If word_valid && word_ready: latch word_in into the shift register, set byte_cnt=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: tx = current byte bit[bit_cnt], LSB first, each bit held for CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of the period:
    - if byte_cnt==BYTES_PER_WORD-1: go to IDLE and pulse word_done=1 for exactly one cycle;
    - otherwise: increment byte_cnt, shift the register by 8 and go to START. There is no idle gap between bytes.
- Latency: the start bit begins on the cycle after the accepting edge. A full word takes exactly 10*BYTES_PER_WORD*CLKS_PER_BIT cycles from the first start-bit cycle to the word_done cycle inclusive-exclusive (40*CLKS_PER_BIT by default).
- Handshake:
  - word_ready is low in every state except IDLE, and busy = ~word_ready after reset.
  - word_valid while busy is ignored; the producer must hold the word until accepted.
  - word_done and word_ready are both high in the first IDLE cycle. A new word accepted in that cycle starts back-to-back.
- Timing: the bit-timer counter runs 0..CLKS_PER_BIT-1 and is sized $clog2(CLKS_PER_BIT). It wraps to 0 at every bit boundary and is reset on acceptance.
- Output registers: tx is driven from a register, so there is no combinational path from word_in or word_valid to tx.
- word_in changes after acceptance have no effect.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: each frame carries an even-parity bit in a PARITY state between DATA and STOP. The bit is the XOR of the 8 data bits, held for CLKS_PER_BIT cycles. Each frame is 11 bits, so a word takes 11*BYTES_PER_WORD*CLKS_PER_BIT cycles.
- When undefined: the PARITY state and its logic are absent, and framing is strictly 8N1.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum: IDLE, START, DATA, PARITY, STOP;
  - localparams for bits-per-byte (8), stop-bit level (1) and start-bit level (0).
- The receive side of the com controller shares the same package.
- One natural sub-module, uart_bit_timer: a parameterized counter with a restart input and a one-cycle bit_tick output.

Test Plan:
- Reset with CLKS_PER_BIT=4, hold reset=0 for 3 cycles, then release -> tx=1, busy=0 and word_done=0 throughout; word_ready=1 on the cycle after release.
- Send 0x12345678 at CLKS_PER_BIT=4 -> the sampled bit stream is the frames for bytes 0x78, 0x56, 0x34, 0x12, each start=0, LSB first, stop=1. word_done pulses once, exactly 160 cycles after the first start-bit cycle.
- Back-to-back words: assert valid with 0xA5A5A5A5 and then 0x0000FFFF in the word_done cycle -> the second start bit immediately follows the first word's final stop bit, with no idle cycle.
- Assert word_valid with 0xDEADBEEF while busy -> word_ready=0; the in-flight word is unaffected and 0xDEADBEEF is sent only after the return to IDLE.
- Pull reset low during DATA of byte 2 -> tx=1 at the next edge and no word_done pulse. A subsequent word 0x00000001 transmits correctly from byte 0.
- With UART_TX_PARITY_EN, send 0x00000007 -> byte 0 parity bit=1, bytes 1-3 parity=0, and word_done fires 176 cycles after the first start bit (CLKS_PER_BIT=4).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the com controller transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic STOP_BIT_LVL  = 1'b1;
  localparam logic START_BIT_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last  = (r_cnt == CNT_LAST);
  assign o_bit_tick = i_enable && w_at_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Word-serializing UART transmitter: one word out as BYTES_PER_WORD frames, LSB byte first.
// Defining UART_TX_PARITY_EN adds an even-parity bit to every frame (8E1).
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 10416,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [8*BYTES_PER_WORD-1:0] word_in,
  input  logic                        word_valid,
  output logic                        word_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        word_done
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int BC_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              w_done_next;
  logic [2:0]        r_bit_cnt;
  logic [2:0]        w_bit_cnt_next;
  logic [2:0]        w_bit_idx;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [BC_W-1:0]   w_byte_cnt_next;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_next;
  logic              w_accept;
  logic              w_bit_tick;

  assign w_accept  = (r_state == IDLE) && r_ready && word_valid;
  assign w_bit_idx = r_bit_cnt + 3'd1;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_accept),
    .i_enable  (r_state != IDLE),
    .o_bit_tick(w_bit_tick)
  );

  // tx is computed one cycle ahead so the line comes straight from a flop.
  always_comb begin
    w_state_next    = r_state;
    w_tx_next       = r_tx;
    w_done_next     = 1'b0;
    w_bit_cnt_next  = r_bit_cnt;
    w_byte_cnt_next = r_byte_cnt;
    w_shift_next    = r_shift;

    case (r_state)
      IDLE: begin
        w_tx_next = STOP_BIT_LVL;
        if (w_accept) begin
          w_shift_next    = word_in;
          w_byte_cnt_next = '0;
          w_bit_cnt_next  = '0;
          w_tx_next       = START_BIT_LVL;
          w_state_next    = START;
        end
      end

      START: begin
        if (w_bit_tick) begin
          w_bit_cnt_next = '0;
          w_tx_next      = r_shift[0];
          w_state_next   = DATA;
        end
      end

      DATA: begin
        if (w_bit_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_tx_next    = ^r_shift[BITS_PER_BYTE-1:0];
            w_state_next = PARITY;
`else
            w_tx_next    = STOP_BIT_LVL;
            w_state_next = STOP;
`endif
          end else begin
            w_bit_cnt_next = w_bit_idx;
            w_tx_next      = r_shift[w_bit_idx];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_tick) begin
          w_tx_next    = STOP_BIT_LVL;
          w_state_next = STOP;
        end
      end
`endif

      STOP: begin
        if (w_bit_tick) begin
          if (r_byte_cnt == LAST_BYTE) begin
            w_tx_next    = STOP_BIT_LVL;
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end else begin
            // next start bit follows immediately, no idle gap between bytes
            w_byte_cnt_next = r_byte_cnt + 1'b1;
            w_shift_next    = r_shift >> BITS_PER_BYTE;
            w_bit_cnt_next  = '0;
            w_tx_next       = START_BIT_LVL;
            w_state_next    = START;
          end
        end
      end

      default: begin
        w_tx_next    = STOP_BIT_LVL;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tx       <= STOP_BIT_LVL;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tx       <= w_tx_next;
      r_ready    <= (w_state_next == IDLE);
      r_busy     <= (w_state_next != IDLE);
      r_done     <= w_done_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_shift    <= w_shift_next;
    end
  end

  assign tx         = r_tx;
  assign word_ready = r_ready;
  assign busy       = r_busy;
  assign word_done  = r_done;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: line-level model of the expected serial waveform, checked every cycle.
module tb_uart_word_tx;

  localparam int C = 4;
  localparam int B = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB  = 11;
  localparam int LAT = 176;
`else
  localparam int FB  = 10;
  localparam int LAT = 160;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        tx;
  logic        busy;
  logic        word_done;

  int checks = 0;
  int errors = 0;

  uart_word_tx #(
    .CLKS_PER_BIT  (C),
    .BYTES_PER_WORD(B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .tx        (tx),
    .busy      (busy),
    .word_done (word_done)
  );

  initial forever #5 clk = ~clk;

  // model state: q holds the expected line level for this cycle and all later ones
  bit   q[$];
  bit   m_live  = 0;
  bit   m_ready = 0;
  bit   m_done  = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cyc = 0;
  bit   cap_on = 0;
  logic cap[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, got, want);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int k = 0; k < B; k++) begin
      logic [7:0] by;
      bit fr[$];
      by = w[8*k +: 8];
      fr.push_back(1'b0);
      for (int j = 0; j < 8; j++) fr.push_back(by[j]);
`ifdef UART_TX_PARITY_EN
      fr.push_back(^by);
`endif
      fr.push_back(1'b1);
      foreach (fr[n]) for (int r = 0; r < C; r++) q.push_back(fr[n]);
    end
  endfunction

  // compare process, then advance the model to the next cycle
  initial forever begin
    @(negedge clk);
    cyc++;
    if (m_live) begin
      chk("tx", tx, (q.size() > 0) ? q[0] : 1'b1);
      chk("busy", busy, q.size() > 0);
      chk("word_ready", word_ready, m_ready);
      chk("word_done", word_done, m_done);
    end
    if (word_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cap_on) cap.push_back(tx);
    if (reset === 1'b0) begin
      m_live = 1;
      q.delete();
      m_ready = 0;
      m_done = 0;
    end else if (m_live) begin
      if (q.size() > 0) begin
        void'(q.pop_front());
        m_done  = (q.size() == 0);
        m_ready = (q.size() == 0);
      end else begin
        m_done = 0;
        if (m_ready && word_valid) begin
          push_word(word_in);
          m_ready = 0;
          acc_cnt++;
          start_cyc = cyc + 1;
        end else begin
          m_ready = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int a0;
    a0 = acc_cnt;
    word_in = w;
    word_valid = 1'b1;
    for (int i = 0; i < 60 * C && acc_cnt == a0; i++) tick();
    if (acc_cnt == a0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout word %0h", w);
    end
    word_valid = 1'b0;
    word_in = $urandom;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < (FB * B + 8) * C && done_cnt == d0; i++) tick();
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout at cycle %0d", cyc);
    end
  endtask

  // independent mid-bit decode of the captured line against a literal word
  task automatic check_decode(input logic [31:0] want, input string nm);
    logic [31:0] got;
    logic        frame_ok;
    logic        s;
    got = '0;
    frame_ok = 1'b1;
    if (cap.size() < B * FB * C) begin
      chk({nm, "_capture_len"}, cap.size(), B * FB * C);
      return;
    end
    for (int k = 0; k < B; k++) begin
      for (int b = 0; b < FB; b++) begin
        s = cap[(k * FB + b) * C + C / 2];
        if (b == 0 && s !== 1'b0) frame_ok = 1'b0;
        if (b == FB - 1 && s !== 1'b1) frame_ok = 1'b0;
        if (b >= 1 && b <= 8) got[8 * k + b - 1] = s;
      end
    end
    chk({nm, "_data"}, got, want);
    chk({nm, "_framing"}, frame_ok, 1'b1);
  endtask

  task automatic send_capture(input logic [31:0] w);
    cap.delete();
    send(w);
    cap_on = 1;
    wait_done();
    cap_on = 0;
  endtask

  initial begin
    int d0;
    int first_done;
    logic [3:0] par;
    reset = 1'b0;
    word_valid = 1'b0;
    word_in = '0;

    // reset held for three edges
    repeat (3) tick();
    chk("ready_in_reset", word_ready, 1'b0);
    reset = 1'b1;
    tick();
    chk("ready_after_release", word_ready, 1'b1);
    tick();

    // single word: literal decode and exact latency
    d0 = done_cnt;
    send_capture(32'h12345678);
    check_decode(32'h12345678, "w12345678");
    chk("latency", done_cyc - start_cyc, LAT);
    repeat (10) tick();
    chk("done_pulses", done_cnt - d0, 1);

    // back-to-back: second word accepted in the word_done cycle
    send(32'hA5A5A5A5);
    send(32'h0000FFFF);
    first_done = done_cyc;
    chk("b2b_no_gap", start_cyc, first_done + 1);
    cap.delete();
    cap_on = 1;
    wait_done();
    cap_on = 0;
    check_decode(32'h0000FFFF, "w0000ffff");

    // valid while busy is ignored until the return to IDLE
    send(32'h0F0F1234);
    word_in = 32'hDEADBEEF;
    word_valid = 1'b1;
    repeat (30) tick();
    chk("ready_while_busy", word_ready, 1'b0);
    d0 = done_cnt;
    send(32'hDEADBEEF);
    chk("deadbeef_after_done", done_cnt - d0, 1);
    cap.delete();
    cap_on = 1;
    wait_done();
    cap_on = 0;
    check_decode(32'hDEADBEEF, "wdeadbeef");
    repeat (5) tick();

    // reset during DATA of byte 2 aborts without word_done
    send(32'hCAFEF00D);
    repeat ((2 * FB + 3) * C) tick();
    d0 = done_cnt;
    reset = 1'b0;
    tick();
    chk("tx_at_abort", tx, 1'b1);
    reset = 1'b1;
    repeat (50 * C) tick();
    chk("no_done_after_abort", done_cnt - d0, 0);
    send_capture(32'h00000001);
    check_decode(32'h00000001, "w00000001");

`ifdef UART_TX_PARITY_EN
    send_capture(32'h00000007);
    for (int k = 0; k < B; k++) par[k] = cap[(k * FB + 9) * C + C / 2];
    chk("parity_bits", par, 4'b0001);
    chk("parity_latency", done_cyc - start_cyc, 176);
`endif

    // randomized traffic with word_in/valid noise while busy
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send($urandom);
      repeat ($urandom_range(1, 20)) begin
        tick();
        word_in = $urandom;
        word_valid = 1'($urandom_range(0, 1));
      end
      word_valid = 1'b0;
    end
    wait_done();
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
